rule_sram_arbiter: RTL and testbench

RULE_SRAM_ARBITER -- requirements
Module: rule_sram_arbiter

---
 rtl/rule_sram_pkg.sv | 32 +++
 rtl/rule_sram_arbiter_if.sv | 62 ++++++
 rtl/rule_sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_rule_sram_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_sram_pkg.sv
// Shared definitions for the rule-table SRAM arbiter: default widths,
// FSM state encoding, requester IDs and the 2-way round-robin pick.
package rule_sram_pkg;

  // Default rule-table geometry: 19-bit word address, 72-bit word (4 x 18-bit entries).
  localparam int unsigned SRAM_ADDR_WIDTH_DEF = 19;
  localparam int unsigned SRAM_DATA_WIDTH_DEF = 72;

  // FSM state encoding.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  // Requester IDs.
  localparam logic REQ_LU   = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Round-robin between the two requesters: on a tie the one not granted last wins.
  function automatic logic rr_pick(input logic lu_req, input logic host_req, input logic last);
    logic pick;
    if (lu_req && host_req) begin
      pick = (last == REQ_HOST) ? REQ_LU : REQ_HOST;
    end else if (lu_req) begin
      pick = REQ_LU;
    end else begin
      pick = REQ_HOST;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rule_sram_arbiter_if.sv
// Bus bundle for the rule SRAM arbiter: lookup requester, host requester and
// the single SRAM read/write port. The arbiter uses the slave modport; the
// requesters and SRAM model sit on the master side.
interface rule_sram_arbiter_if #(
  parameter int unsigned SRAM_ADDR_WIDTH = rule_sram_pkg::SRAM_ADDR_WIDTH_DEF,
  parameter int unsigned SRAM_DATA_WIDTH = rule_sram_pkg::SRAM_DATA_WIDTH_DEF
);

  // Lookup requester (read-only).
  logic                       lu_req;
  logic [SRAM_ADDR_WIDTH-1:0] lu_addr;
  logic                       lu_grant;
  logic                       lu_vld;
  logic [SRAM_DATA_WIDTH-1:0] lu_data;

  // Host requester (read or write).
  logic                       host_req;
  logic                       host_rd_wr_L;
  logic [SRAM_ADDR_WIDTH-1:0] host_addr;
  logic [SRAM_DATA_WIDTH-1:0] host_wr_data;
  logic                       host_grant;
  logic                       host_done;
  logic [SRAM_DATA_WIDTH-1:0] host_rd_data;

  // SRAM read port.
  logic                       rd_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr;
  logic                       rd_0_ack;
  logic                       rd_0_vld;
  logic [SRAM_DATA_WIDTH-1:0] rd_0_data;

  // SRAM write port.
  logic                       wr_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr;
  logic [SRAM_DATA_WIDTH-1:0] wr_0_data;
  logic                       wr_0_ack;

  // Arbiter side.
  modport slave (
    input  lu_req, lu_addr,
    input  host_req, host_rd_wr_L, host_addr, host_wr_data,
    input  rd_0_ack, rd_0_vld, rd_0_data,
    input  wr_0_ack,
    output lu_grant, lu_vld, lu_data,
    output host_grant, host_done, host_rd_data,
    output rd_0_req, rd_0_addr,
    output wr_0_req, wr_0_addr, wr_0_data
  );

  // Requester / SRAM side.
  modport master (
    output lu_req, lu_addr,
    output host_req, host_rd_wr_L, host_addr, host_wr_data,
    output rd_0_ack, rd_0_vld, rd_0_data,
    output wr_0_ack,
    input  lu_grant, lu_vld, lu_data,
    input  host_grant, host_done, host_rd_data,
    input  rd_0_req, rd_0_addr,
    input  wr_0_req, wr_0_addr, wr_0_data
  );

endinterface

// File: rtl/rule_sram_arbiter.sv
// Two-way arbiter between a read-only lookup engine and a host onto a single
// rule-table SRAM port. One SRAM transaction is outstanding at a time; all
// outputs are registered.
// Build option: RULE_SRAM_LOOKUP_PRIO_EN gives lookup strict priority on ties
// and removes the last-winner register; otherwise ties alternate round-robin.
module rule_sram_arbiter
  import rule_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
  parameter int unsigned SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rule_sram_arbiter_if.slave bus
);

  logic [1:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       rd_req_q, rd_req_d;
  logic                       wr_req_q, wr_req_d;
  logic                       lu_grant_q, lu_grant_d;
  logic                       host_grant_q, host_grant_d;
  logic                       lu_vld_q, lu_vld_d;
  logic                       host_done_q, host_done_d;
  logic [SRAM_DATA_WIDTH-1:0] lu_data_q, lu_data_d;
  logic [SRAM_DATA_WIDTH-1:0] host_rd_data_q, host_rd_data_d;

  logic any_req;
  logic winner;
  logic rd_capture;

  assign any_req = bus.lu_req | bus.host_req;

`ifdef RULE_SRAM_LOOKUP_PRIO_EN
  // Lookup wins every tie; no history is kept.
  always_comb begin
    winner = bus.lu_req ? REQ_LU : REQ_HOST;
  end
`else
  logic last_q, last_d;

  // Pick the requester that did not win last time when both are asking.
  always_comb begin
    winner = rr_pick(bus.lu_req, bus.host_req, last_q);
    last_d = last_q;
    if ((state_q == IDLE) && any_req) begin
      last_d = winner;
    end
  end

  // Last-winner history; starts at host so lookup takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_HOST;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Read data is taken in RD_REQ when ack and vld coincide, else in RD_DATA.
  always_comb begin
    rd_capture = 1'b0;
    if (state_q == RD_REQ) begin
      rd_capture = bus.rd_0_ack & bus.rd_0_vld;
    end else if (state_q == RD_DATA) begin
      rd_capture = bus.rd_0_vld;
    end
  end

  // Next-state, SRAM request and completion-pulse logic.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_req_d       = rd_req_q;
    wr_req_d       = wr_req_q;
    lu_grant_d     = 1'b0;
    host_grant_d   = 1'b0;
    lu_vld_d       = 1'b0;
    host_done_d    = 1'b0;
    lu_data_d      = lu_data_q;
    host_rd_data_d = host_rd_data_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          if (winner == REQ_LU) begin
            // Lookup is read-only; its direction is implied.
            addr_d     = bus.lu_addr;
            lu_grant_d = 1'b1;
            rd_req_d   = 1'b1;
            state_d    = RD_REQ;
          end else begin
            addr_d       = bus.host_addr;
            wdata_d      = bus.host_wr_data;
            host_grant_d = 1'b1;
            if (bus.host_rd_wr_L) begin
              rd_req_d = 1'b1;
              state_d  = RD_REQ;
            end else begin
              wr_req_d = 1'b1;
              state_d  = WR_REQ;
            end
          end
        end
      end

      RD_REQ: begin
        if (bus.rd_0_ack) begin
          rd_req_d = 1'b0;
          state_d  = bus.rd_0_vld ? IDLE : RD_DATA;
        end
      end

      RD_DATA: begin
        if (bus.rd_0_vld) begin
          state_d = IDLE;
        end
      end

      WR_REQ: begin
        if (bus.wr_0_ack) begin
          wr_req_d    = 1'b0;
          host_done_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase

    // Route captured read data to whichever requester owns the transaction.
    if (rd_capture) begin
      if (owner_q == REQ_LU) begin
        lu_data_d = bus.rd_0_data;
        lu_vld_d  = 1'b1;
      end else begin
        host_rd_data_d = bus.rd_0_data;
        host_done_d    = 1'b1;
      end
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= REQ_LU;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_req_q       <= 1'b0;
      wr_req_q       <= 1'b0;
      lu_grant_q     <= 1'b0;
      host_grant_q   <= 1'b0;
      lu_vld_q       <= 1'b0;
      host_done_q    <= 1'b0;
      lu_data_q      <= '0;
      host_rd_data_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_req_q       <= rd_req_d;
      wr_req_q       <= wr_req_d;
      lu_grant_q     <= lu_grant_d;
      host_grant_q   <= host_grant_d;
      lu_vld_q       <= lu_vld_d;
      host_done_q    <= host_done_d;
      lu_data_q      <= lu_data_d;
      host_rd_data_q <= host_rd_data_d;
    end
  end

  // Both SRAM ports share the registered address, held stable for the whole request.
  assign bus.rd_0_req     = rd_req_q;
  assign bus.rd_0_addr    = addr_q;
  assign bus.wr_0_req     = wr_req_q;
  assign bus.wr_0_addr    = addr_q;
  assign bus.wr_0_data    = wdata_q;
  assign bus.lu_grant     = lu_grant_q;
  assign bus.lu_vld       = lu_vld_q;
  assign bus.lu_data      = lu_data_q;
  assign bus.host_grant   = host_grant_q;
  assign bus.host_done    = host_done_q;
  assign bus.host_rd_data = host_rd_data_q;

endmodule

// File: tb/tb_rule_sram_arbiter.sv
// Directed bench for rule_sram_arbiter: reset state, lookup read, delayed host
// write, tie arbitration, same-cycle ack/vld and reset mid-read.
module tb_rule_sram_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 72;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rule_sram_arbiter_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) bus ();

  rule_sram_arbiter #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic             exp_lu;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rword;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.lu_req       = 1'b0;
    bus.lu_addr      = '0;
    bus.host_req     = 1'b0;
    bus.host_rd_wr_L = 1'b1;
    bus.host_addr    = '0;
    bus.host_wr_data = '0;
    bus.rd_0_ack     = 1'b0;
    bus.rd_0_vld     = 1'b0;
    bus.rd_0_data    = '0;
    bus.wr_0_ack     = 1'b0;

    // Reset state: requests present during reset must be ignored.
    bus.lu_req = 1'b1;
    repeat (3) tick();
    chk1("rst_lu_grant", bus.lu_grant, 1'b0);
    chk1("rst_host_grant", bus.host_grant, 1'b0);
    chk1("rst_lu_vld", bus.lu_vld, 1'b0);
    chk1("rst_host_done", bus.host_done, 1'b0);
    chk1("rst_rd_req", bus.rd_0_req, 1'b0);
    chk1("rst_wr_req", bus.wr_0_req, 1'b0);
    chka("rst_rd_addr", bus.rd_0_addr, '0);
    chkd("rst_lu_data", bus.lu_data, '0);
    chkd("rst_host_rd_data", bus.host_rd_data, '0);
    bus.lu_req = 1'b0;
    reset = 1'b1;
    tick();

    // Lookup read of address 0: ack in the grant cycle, vld two cycles later.
    rword = 72'h00_0050_0000_0000_0000;
    bus.lu_req  = 1'b1;
    bus.lu_addr = 19'h00000;
    tick();
    chk1("s1_lu_grant", bus.lu_grant, 1'b1);
    chk1("s1_host_grant", bus.host_grant, 1'b0);
    chk1("s1_rd_req", bus.rd_0_req, 1'b1);
    chka("s1_rd_addr", bus.rd_0_addr, 19'h00000);
    bus.lu_req   = 1'b0;
    bus.rd_0_ack = 1'b1;
    tick();
    bus.rd_0_ack = 1'b0;
    chk1("s1_grant_pulse", bus.lu_grant, 1'b0);
    chk1("s1_rd_req_drop", bus.rd_0_req, 1'b0);
    tick();
    chk1("s1_no_early_vld", bus.lu_vld, 1'b0);
    bus.rd_0_vld  = 1'b1;
    bus.rd_0_data = rword;
    tick();
    bus.rd_0_vld  = 1'b0;
    bus.rd_0_data = '0;
    chk1("s1_lu_vld", bus.lu_vld, 1'b1);
    chkd("s1_lu_data", bus.lu_data, rword);
    chk1("s1_no_host_done", bus.host_done, 1'b0);
    tick();
    chk1("s1_vld_pulse", bus.lu_vld, 1'b0);
    chk1("s1_no_regrant", bus.lu_grant, 1'b0);

    // Host write to 0x00003, ack on the fifth request cycle.
    wdata = 72'hAB_CDEF_0123_4567_89AB;
    bus.host_req     = 1'b1;
    bus.host_rd_wr_L = 1'b0;
    bus.host_addr    = 19'h00003;
    bus.host_wr_data = wdata;
    tick();
    chk1("s2_host_grant", bus.host_grant, 1'b1);
    chk1("s2_rd_req", bus.rd_0_req, 1'b0);
    bus.host_req     = 1'b0;
    bus.host_wr_data = '0;
    bus.host_addr    = 19'h7FFFF;
    for (int i = 0; i < 5; i++) begin
      chk1("s2_wr_req_held", bus.wr_0_req, 1'b1);
      chka("s2_wr_addr", bus.wr_0_addr, 19'h00003);
      chkd("s2_wr_data", bus.wr_0_data, wdata);
      chk1("s2_no_early_done", bus.host_done, 1'b0);
      if (i == 4) bus.wr_0_ack = 1'b1;
      tick();
    end
    bus.wr_0_ack = 1'b0;
    chk1("s2_host_done", bus.host_done, 1'b1);
    chk1("s2_wr_req_drop", bus.wr_0_req, 1'b0);
    tick();
    chk1("s2_done_pulse", bus.host_done, 1'b0);

    // Three ties with both requests held; host reads.
    bus.lu_req       = 1'b1;
    bus.lu_addr      = 19'h00007;
    bus.host_req     = 1'b1;
    bus.host_rd_wr_L = 1'b1;
    bus.host_addr    = 19'h00005;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 20 && !(bus.lu_grant || bus.host_grant); w++) tick();
      chk1("tie_grant_seen", bus.lu_grant | bus.host_grant, 1'b1);
`ifdef RULE_SRAM_LOOKUP_PRIO_EN
      exp_lu = 1'b1;
`else
      exp_lu = (k != 1);
`endif
      chk1("tie_lu_grant", bus.lu_grant, exp_lu);
      chk1("tie_host_grant", bus.host_grant, !exp_lu);
      chka("tie_rd_addr", bus.rd_0_addr, exp_lu ? 19'h00007 : 19'h00005);
      if (k == 2) begin
        bus.lu_req   = 1'b0;
        bus.host_req = 1'b0;
      end
      rword = 72'h100 + 72'(k);
      bus.rd_0_ack  = 1'b1;
      bus.rd_0_vld  = 1'b1;
      bus.rd_0_data = rword;
      tick();
      bus.rd_0_ack = 1'b0;
      bus.rd_0_vld = 1'b0;
      chk1("tie_lu_vld", bus.lu_vld, exp_lu);
      chk1("tie_host_done", bus.host_done, !exp_lu);
      if (exp_lu) chkd("tie_lu_data", bus.lu_data, rword);
      else chkd("tie_host_rd_data", bus.host_rd_data, rword);
    end
    tick();
    chk1("tie_idle_no_grant", bus.lu_grant | bus.host_grant, 1'b0);

    // Ack and vld in the same cycle.
    bus.lu_req  = 1'b1;
    bus.lu_addr = 19'h00010;
    tick();
    chk1("s4_lu_grant", bus.lu_grant, 1'b1);
    bus.lu_req    = 1'b0;
    bus.rd_0_ack  = 1'b1;
    bus.rd_0_vld  = 1'b1;
    bus.rd_0_data = 72'h123;
    tick();
    bus.rd_0_ack  = 1'b0;
    bus.rd_0_vld  = 1'b0;
    bus.rd_0_data = '0;
    chk1("s4_lu_vld", bus.lu_vld, 1'b1);
    chkd("s4_lu_data", bus.lu_data, 72'h123);
    chk1("s4_rd_req_drop", bus.rd_0_req, 1'b0);
    tick();
    chk1("s4_vld_pulse", bus.lu_vld, 1'b0);

    // Reset while in RD_DATA, then a stale vld after release.
    bus.lu_req  = 1'b1;
    bus.lu_addr = 19'h00020;
    tick();
    chk1("s5_lu_grant", bus.lu_grant, 1'b1);
    bus.lu_req   = 1'b0;
    bus.rd_0_ack = 1'b1;
    tick();
    bus.rd_0_ack = 1'b0;
    chk1("s5_in_rd_data", bus.rd_0_req, 1'b0);
    reset = 1'b0;
    #1;
    chk1("s5_rst_lu_vld", bus.lu_vld, 1'b0);
    chkd("s5_rst_lu_data", bus.lu_data, '0);
    tick();
    reset = 1'b1;
    bus.rd_0_vld  = 1'b1;
    bus.rd_0_data = 72'hDEAD;
    tick();
    bus.rd_0_vld  = 1'b0;
    bus.rd_0_data = '0;
    chk1("s5_stale_vld_ignored", bus.lu_vld, 1'b0);
    chkd("s5_stale_data_ignored", bus.lu_data, '0);
    tick();
    chk1("s5_no_vld_later", bus.lu_vld, 1'b0);
    bus.lu_req  = 1'b1;
    bus.lu_addr = 19'h00021;
    tick();
    chk1("s5_regrant", bus.lu_grant, 1'b1);
    chk1("s5_rd_req", bus.rd_0_req, 1'b1);
    chka("s5_rd_addr", bus.rd_0_addr, 19'h00021);
    bus.lu_req    = 1'b0;
    bus.rd_0_ack  = 1'b1;
    bus.rd_0_vld  = 1'b1;
    bus.rd_0_data = 72'h77;
    tick();
    bus.rd_0_ack = 1'b0;
    bus.rd_0_vld = 1'b0;
    chk1("s5_lu_vld", bus.lu_vld, 1'b1);
    chkd("s5_lu_data", bus.lu_data, 72'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
